mult_booth: RTL

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_booth.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mult_booth.sv
// rtl/mult_booth.sv - radix-2 Booth 32x32 signed multiplier driving an external 32-bit adder (optional overflow flag: MULT_EXCEPTION_EN)
module mult_booth (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] adder_A,
    output logic [31:0] adder_B,
    output logic        adder_Cin,
    input  logic [31:0] adder_S,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_count;
    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_q;
    logic [31:0] r_result;

    logic        w_step;
    logic        w_finish;
    logic        w_sign;

    // A Booth step happens on counts 0..31; count 32 is the settle cycle that
    // moves the product into the result register, giving 33 edges of latency.
    assign w_step   = (r_state == RUN) && (r_count != 6'd32);
    assign w_finish = (r_state == RUN) && (r_count == 6'd32);

    // When the add/subtract overflows 32 bits the true 33-bit sign is the
    // common operand sign rather than the sum MSB.
    assign w_sign = ((adder_A[31] == adder_B[31]) && (adder_S[31] != adder_A[31]))
                    ? adder_A[31] : adder_S[31];

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start pulse in any state (re)starts the run
    always_comb begin
        w_state_next = r_state;
        if (ctrl_MULT) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                RUN:     w_state_next = (r_count == 6'd32) ? DONE : RUN;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Adder operand selection from the Booth pair {lo[0], q-1}
    always_comb begin
        adder_A   = 32'd0;
        adder_B   = 32'd0;
        adder_Cin = 1'b0;
        if (w_step) begin
            adder_A = r_hi;
            case ({r_lo[0], r_q})
                2'b01: begin
                    adder_B   = r_m;
                    adder_Cin = 1'b0;
                end
                2'b10: begin
                    adder_B   = ~r_m;
                    adder_Cin = 1'b1;
                end
                default: begin
                    adder_B   = 32'd0;
                    adder_Cin = 1'b0;
                end
            endcase
        end
    end

    // Operand load, Booth add-and-shift, and result capture
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count  <= 6'd0;
            r_m      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_q      <= 1'b0;
            r_result <= 32'd0;
        end else if (ctrl_MULT) begin
            r_count  <= 6'd0;
            r_m      <= data_operandA;
            r_hi     <= 32'd0;
            r_lo     <= data_operandB;
            r_q      <= 1'b0;
            r_result <= 32'd0;
        end else if (w_step) begin
            r_count <= r_count + 6'd1;
            r_hi    <= {w_sign, adder_S[31:1]};
            r_lo    <= {adder_S[0], r_lo[31:1]};
            r_q     <= r_lo[0];
        end else if (w_finish) begin
            r_result <= r_lo;
        end
    end

`ifdef MULT_EXCEPTION_EN
    logic r_exc;

    // Overflow: the high product word is not a pure sign extension of lo[31]
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_exc <= 1'b0;
        end else if (ctrl_MULT) begin
            r_exc <= 1'b0;
        end else if (w_finish) begin
            r_exc <= (r_hi != {32{r_lo[31]}});
        end
    end

    assign data_exception = r_exc;
`else
    assign data_exception = 1'b0;
`endif

    assign data_result    = r_result;
    assign data_resultRDY = (r_state == DONE);

endmodule
